// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the byte-serial add/subtract controller:
// FSM state encoding, datapath byte width and the signed-overflow rule.
package serial_add_ctrl_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_rca8bit.sv
// 8-bit ripple-carry adder used as the single byte-wide datapath slice.
module RCA8bit
    import serial_add_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] A,
    input  logic [BYTE_W-1:0] B,
    input  logic              Cin,
    output logic [BYTE_W-1:0] S,
    output logic              Cout
);

    // Ripple the carry bit by bit through a chain of full adders.
    always_comb begin
        logic v_c;
        v_c = Cin;
        S   = {BYTE_W{1'b0}};
        for (int i = 0; i < BYTE_W; i++) begin
            S[i] = A[i] ^ B[i] ^ v_c;
            v_c  = (A[i] & B[i]) | (A[i] & v_c) | (B[i] & v_c);
        end
        Cout = v_c;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Byte-serial adder/subtractor controller. An accepted operation is
// processed one byte per clock through a single 8-bit ripple adder,
// least-significant byte first, then held in DONE until consumed.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [BYTE_W*NBYTES-1:0] A,
    input  logic [BYTE_W*NBYTES-1:0] B,
    input  logic                     Cin,
    input  logic                     Sub,
    output logic [BYTE_W*NBYTES-1:0] S,
    output logic                     Cout,
    output logic                     Ovf,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic                     busy
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_beff;
    logic [W-1:0]      r_s;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic              r_start_ready;
    logic              r_done_valid;
    logic              r_busy;

    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_sum;
    logic              w_cout;
    logic              w_last;
    logic              w_ovf;

    // Select the current byte of the captured operands for the adder.
    always_comb begin
        w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
        w_b_byte = r_beff[r_idx*BYTE_W +: BYTE_W];
    end

    RCA8bit u_rca (
        .A    (w_a_byte),
        .B    (w_b_byte),
        .Cin  (r_carry),
        .S    (w_sum),
        .Cout (w_cout)
    );

    assign w_last = (r_idx == IDX_LAST);
    assign w_ovf  = signed_ovf(r_a[W-1], r_beff[W-1], w_sum[BYTE_W-1]);

    // Next-state decode: IDLE -> ADD on accept, ADD -> DONE after the top byte,
    // DONE -> IDLE once the consumer takes the result.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_valid) begin
                    w_state_nxt = ST_ADD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ADD;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus handshake/status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_start_ready <= 1'b1;
            r_done_valid  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_ready <= (w_state_nxt == ST_IDLE);
            r_done_valid  <= (w_state_nxt == ST_DONE);
            r_busy        <= (w_state_nxt == ST_ADD);
        end
    end

    // Operand capture on accept, then one result byte per ADD cycle.
    // The effective B is stored already inverted for subtraction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= {W{1'b0}};
            r_beff  <= {W{1'b0}};
            r_s     <= {W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_a     <= A;
                        r_beff  <= Sub ? ~B : B;
                        r_carry <= Sub ? 1'b1 : Cin;
                        r_idx   <= {IDX_W{1'b0}};
                    end else begin
                        r_a     <= r_a;
                        r_beff  <= r_beff;
                        r_carry <= r_carry;
                        r_idx   <= r_idx;
                    end
                end
                ST_ADD: begin
                    r_s[r_idx*BYTE_W +: BYTE_W] <= w_sum;
                    r_carry <= w_cout;
                    r_cout  <= w_cout;
                    // Index returns to 0 after the top byte so it never
                    // addresses past the operand.
                    if (w_last) begin
                        r_idx <= {IDX_W{1'b0}};
                        r_ovf <= w_ovf;
                    end else begin
                        r_idx <= r_idx + IDX_ONE;
                        r_ovf <= r_ovf;
                    end
                end
                default: begin
                    r_idx   <= r_idx;
                    r_carry <= r_carry;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign done_valid  = r_done_valid;
    assign busy        = r_busy;
    assign S           = r_s;
    assign Cout        = r_cout;
    assign Ovf         = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (NBYTES=4): stimulus pushes the
// hand-computed result of every accepted op; a negedge monitor pops and
// compares whenever a result is handed over (done_valid && done_ready).
module tb_serial_add_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic [W-1:0] S;
    logic         Cout;
    logic         Ovf;
    logic         done_valid;
    logic         done_ready;
    logic         busy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_add_ctrl #(.NBYTES(NB)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (A),
        .B           (B),
        .Cin         (Cin),
        .Sub         (Sub),
        .S           (S),
        .Cout        (Cout),
        .Ovf         (Ovf),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every delivered result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && done_valid && done_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", {30'd0, S, Cout, Ovf}, {30'd0, e.s, e.c, e.o});
            end
        end
    end

    task automatic wait_ready();
        int cyc = 0;
        while (!start_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!start_ready) check("start_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done_valid) check("done_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic consume();
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit scramble);
        wait_ready();
        A = a; B = b; Cin = cin; Sub = sub; start_valid = 1'b1;
        q.push_back('{s: es, c: ec, o: eo});
        @(posedge clk); #1;                // accept edge (edge 0)
        start_valid = 1'b0;
        for (int k = 1; k <= NB; k++) begin
            if (scramble) begin
                A = $urandom; B = $urandom; Cin = ~Cin; Sub = ~Sub;
            end
            @(posedge clk); #1;
            if (k == 1)      check("busy_in_add", {63'd0, busy}, 64'd1);
            if (k == NB - 1) check("done_early", {63'd0, done_valid}, 64'd0);
            if (k == NB)     check("done_latency", {63'd0, done_valid}, 64'd1);
        end
        wait_done();
        consume();
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {29'd0, S, Cout, Ovf, done_valid, busy, start_ready},
              {29'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

        // Hold DONE with start_valid asserted, then release and re-accept.
        wait_ready();
        A = 32'h12345678; B = 32'h11111111; Cin = 1'b0; Sub = 1'b0; start_valid = 1'b1;
        q.push_back('{s: 32'h23456789, c: 1'b0, o: 1'b0});
        @(posedge clk); #1;
        wait_done();
        for (int i = 0; i < 10; i++) begin
            A = $urandom; B = $urandom;
            @(posedge clk); #1;
            check("hold_s", {32'd0, S}, {32'd0, 32'h23456789});
            check("hold_flags", {62'd0, start_ready, done_valid}, {62'd0, 1'b0, 1'b1});
        end
        A = 32'h00000001; B = 32'h00000002;
        q.push_back('{s: 32'h00000003, c: 1'b0, o: 1'b0});
        done_ready = 1'b1;
        @(posedge clk); #1;                // DONE -> IDLE, start_valid still high
        done_ready = 1'b0;
        check("idle_after_done", {62'd0, start_ready, done_valid}, {62'd0, 1'b1, 1'b0});
        @(posedge clk); #1;                // accept on the following edge
        start_valid = 1'b0;
        check("accept_after_idle", {63'd0, busy}, 64'd1);
        wait_done();
        consume();

        // Reset during ADD aborts without a result.
        wait_ready();
        A = 32'h00000011; B = 32'h00000022; Cin = 1'b0; Sub = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;                // edge 0
        start_valid = 1'b0;
        @(posedge clk); #1;                // edge 1
        rst = 1'b1;
        #1;
        check("abort_outputs", {29'd0, S, Cout, Ovf, done_valid, busy, start_ready},
              {29'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(posedge clk); #1;                // edge 2 under reset
        rst = 1'b0;
        run_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0);

        // Inputs changing every cycle during ADD must not disturb the result.
        run_op(32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b1);
        run_op(32'h00000001, 32'h00000002, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, operand width in bytes; legal range 2..16.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_valid  in  1  requester presents an operation.
REQ-005 SHALL have port start_ready  out  1  controller can accept an operation.
REQ-006 SHALL have ports A, B  in  8*NBYTES  operands, unsigned or two's complement.
REQ-007 SHALL have port Cin  in  1  carry-in, used for add only.
REQ-008 SHALL have port Sub  in  1  1 = A-B, 0 = A+B+Cin.
REQ-009 SHALL have port S  out  8*NBYTES  result.
REQ-010 SHALL have port Cout  out  1  final carry-out (for subtraction, 1 = no borrow).
REQ-011 SHALL have port Ovf  out  1  signed overflow of the result.
REQ-012 SHALL have port done_valid  out  1  result valid.
REQ-013 SHALL have port done_ready  in  1  consumer accepts the result.
REQ-014 SHALL have port busy  out  1  high in ADD state.

Function
REQ-015 SHALL implement the FSM IDLE -> ADD -> DONE -> IDLE.
REQ-016 start_ready SHALL be 1 only in IDLE; start_valid is ignored in every other state.
REQ-017 On an IDLE edge with start_valid=1, the block SHALL capture A, B and Sub, set carry reg to (Sub ? 1 : Cin), clear byte index to 0, and go to ADD.
REQ-018 The effective B SHALL be ~B when Sub=1, otherwise B.
REQ-019 In ADD, a single 8-bit adder SHALL sum byte[idx] of captured A, byte[idx] of effective B, and the carry reg.
REQ-020 Each ADD edge SHALL write the sum into S byte[idx], load the adder carry-out into the carry reg, and increment idx.
REQ-021 On the ADD edge with idx=NBYTES-1, the block SHALL also go to DONE.
REQ-022 Latency: the accept edge is edge 0, and done_valid SHALL be 1 from edge NBYTES onward.
REQ-023 done_valid SHALL be 1 only in DONE.
REQ-024 S, Cout and Ovf SHALL hold stable throughout DONE.
REQ-025 On a DONE edge with done_ready=1, the block SHALL go to IDLE; a new start is accepted no earlier than the following edge, so the block runs no back-to-back ops.
REQ-026 In DONE with done_ready=0, the block SHALL hold indefinitely.
REQ-027 Cout SHALL equal the carry reg after the final byte.
REQ-028 Ovf SHALL equal (A[MSB] == Beff[MSB]) && (S[MSB] != A[MSB]), registered in the final ADD edge.
REQ-029 S, Cout and Ovf SHALL retain their last values in IDLE until the next accepted op's first ADD edge overwrites them byte by byte.
REQ-030 S bytes not yet written during ADD are don't-care to observers; only done_valid qualifies S.
REQ-031 Input changes on A, B, Cin or Sub after the accept edge SHALL NOT affect the result.

Reset
REQ-032 While rst=1 the block SHALL be in IDLE with idx=0, carry reg=0, S=0, Cout=0, Ovf=0, done_valid=0, busy=0, start_ready=1.
REQ-033 Assertion of rst mid-ADD or in DONE SHALL abort immediately with no result delivered.
REQ-034 After rst deasserts, the first accepted op SHALL behave as from power-up.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE, ADD, DONE) and the constant BYTE_W=8.
REQ-036 The byte datapath SHALL be one instance of the existing 8-bit ripple-carry adder module RCA8bit; the controller adds no other arithmetic except the Ovf compare and the byte mux.

Verification
REQ-037 NBYTES=4, add A=0x000000FF, B=0x00000001, Cin=0 -> S=0x00000100, Cout=0, Ovf=0; done_valid at edge 4.
REQ-038 Add A=0xFFFFFFFF, B=0x00000000, Cin=1 -> S=0x00000000, Cout=1, Ovf=0 (carry ripples through all 4 bytes).
REQ-039 Add A=0x7FFFFFFF, B=0x00000001 -> S=0x80000000, Ovf=1, Cout=0; Sub A=0x00000005, B=0x00000007 -> S=0xFFFFFFFE, Cout=0, Ovf=0.
REQ-040 Hold done_ready=0 for 10 cycles with start_valid=1 -> S stable, start_ready=0, no new accept; done_ready=1 -> IDLE, then accept on the next edge.
REQ-041 Assert rst at edge 2 of an op -> all outputs at reset values; a following op A=3, B=4 -> S=7.
REQ-042 Change A and B every cycle during ADD -> result equals the sum of the operands captured at the accept edge.
